// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, I_WAIT, D_WAIT)
//   arb_src_e   : which pipeline stage owns the outstanding transaction
//   wait_src()  : maps a WAIT state to the stage it is serving
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } arb_src_e;

  function automatic arb_src_e wait_src(input arb_state_e s);
    return (s == D_WAIT) ? SRC_DM : SRC_IF;
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state timer for the memory port arbiter.
// Counts cycles while enable is high; clear has priority and zeroes the count.
// expired is high during the TIMEOUT_CYC-th consecutive enabled cycle, so the
// owning FSM can abort in that same cycle.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     zero the counter
//   enable    count this cycle (a WAIT state is active)
//   expired   the current enabled cycle is the last one allowed
module arb_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between IF-stage fetch and MEM-stage
// load/store. One transaction outstanding at a time; data side wins ties.
// Optional feature macro: ARB_PERF_CNT_EN adds stall-cycle counters.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_done)
//   if_rdata/if_done               fetch data and one-cycle completion
//   dm_req/dm_addr/dm_w_en/dm_wdata load/store request (held until dm_done)
//   dm_rdata/dm_done               load data and one-cycle completion
//   mem_req/mem_addr/mem_w_en/mem_wdata  registered memory request
//   mem_rdata/mem_ack              memory response
//   stall_if, stall_mem            per-stage stall requests
//   bus_err                        sticky timeout flag
//   perf_if_stall, perf_dm_stall   stall-cycle counters (ARB_PERF_CNT_EN only)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W/8-1:0] dm_w_en,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_w_en,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_if,
  output logic                stall_mem,
`ifdef ARB_PERF_CNT_EN
  output logic                bus_err,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_dm_stall
`else
  output logic                bus_err
`endif
);

  arb_state_e state, state_nxt;
  logic       in_wait;
  logic       expired;
  logic       finish;
  arb_src_e   src;

  assign in_wait = (state != IDLE);
  assign src     = wait_src(state);
  // A WAIT state ends on ack or on the last allowed cycle; ack wins a tie.
  assign finish  = in_wait && (mem_ack || expired);

  arb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait || finish),
    .enable  (in_wait),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    case (state)
      IDLE: begin
        if (dm_req)      state_nxt = D_WAIT;
        else if (if_req) state_nxt = I_WAIT;
      end
      I_WAIT, D_WAIT: begin
        mem_req = 1'b1;
        if (finish) state_nxt = IDLE;
        // A flushed requester (req dropped) gets no done; timeout returns 0 data.
        if (src == SRC_IF) begin
          if_done = finish && if_req;
          if (if_done && mem_ack) if_rdata = mem_rdata;
        end else begin
          dm_done = finish && dm_req;
          if (dm_done && mem_ack) dm_rdata = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_w_en  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (dm_req) begin
        mem_addr  <= dm_addr;
        mem_w_en  <= dm_w_en;
        mem_wdata <= dm_wdata;
      end else if (if_req) begin
        mem_addr  <= if_addr;
        mem_w_en  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              bus_err <= 1'b0;
    else if (in_wait && expired && !mem_ack) bus_err <= 1'b1;
  end

  assign stall_if  = if_req && !if_done;
  assign stall_mem = dm_req && !dm_done;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
    end else begin
      if (stall_if)  perf_if_stall <= perf_if_stall + 32'd1;
      if (stall_mem) perf_dm_stall <= perf_dm_stall + 32'd1;
    end
  end
`else
  // Stall-cycle counters are not built in this configuration.
`endif

endmodule
